// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised FIFO family: mode selectors and the
// width helpers that derive pointer and occupancy widths from the depth.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read.
// No reset, so it maps onto distributed (LUT) RAM.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_fwft.sv
// Parametrised synchronous FIFO with optional first-word-fall-through output,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int FWFT      = FIFO_STD,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int PTR_W     = ptr_bits(DEPTH),
    parameter int CNT_W     = cnt_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             almost_full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam bit FALL_THROUGH = (FWFT == FIFO_FWFT);

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_fwft: DEPTH must be at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_fwft: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_fwft: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic             full_q, empty_q, af_q, ae_q;
    logic             ovf_q, udf_q;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] rd_data;

    assign wr_acc    = wr_en && !full_q;
    assign rd_acc    = rd_en && !empty_q;
    assign count_nxt = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_W'(DEPTH));
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= CNT_W'(AF_THRESH));
            ae_q    <= (count_nxt <= CNT_W'(AE_THRESH));
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en && full_q) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (rd_en && empty_q) begin
                udf_q <= 1'b1;
            end else if (err_clr) begin
                udf_q <= 1'b0;
            end
        end
    end

    if (FALL_THROUGH) begin : g_fwft
        assign dout = empty_q ? '0 : rd_data;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rd_data;
            end
        end

        assign dout = dout_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_fwft.sv
// Directed bench for fifo_fwft: three instances cover standard mode with
// thresholds (a_), a non-power-of-two depth (b_) and fall-through mode (c_).
module tb_fifo_fwft;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;

    logic       a_wr, a_rd, a_clr, a_full, a_af, a_empty, a_ae, a_ovf, a_udf;
    logic [7:0] a_din, a_dout;
    logic [3:0] a_count;
    logic       b_wr, b_rd, b_clr, b_full, b_af, b_empty, b_ae, b_ovf, b_udf;
    logic [7:0] b_din, b_dout;
    logic [2:0] b_count;
    logic       c_wr, c_rd, c_clr, c_full, c_af, c_empty, c_ae, c_ovf, c_udf;
    logic [7:0] c_din, c_dout;
    logic [3:0] c_count;

    always #5 clk = ~clk;

    fifo_fwft #(.WIDTH(8), .DEPTH(8), .FWFT(FIFO_STD), .AF_THRESH(6), .AE_THRESH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(a_wr), .din(a_din), .full(a_full),
        .almost_full(a_af), .rd_en(a_rd), .dout(a_dout), .empty(a_empty),
        .almost_empty(a_ae), .count(a_count), .err_clr(a_clr),
        .overflow(a_ovf), .underflow(a_udf));

    fifo_fwft #(.WIDTH(8), .DEPTH(5), .FWFT(FIFO_STD)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(b_wr), .din(b_din), .full(b_full),
        .almost_full(b_af), .rd_en(b_rd), .dout(b_dout), .empty(b_empty),
        .almost_empty(b_ae), .count(b_count), .err_clr(b_clr),
        .overflow(b_ovf), .underflow(b_udf));

    fifo_fwft #(.WIDTH(8), .DEPTH(8), .FWFT(FIFO_FWFT)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_en(c_wr), .din(c_din), .full(c_full),
        .almost_full(c_af), .rd_en(c_rd), .dout(c_dout), .empty(c_empty),
        .almost_empty(c_ae), .count(c_count), .err_clr(c_clr),
        .overflow(c_ovf), .underflow(c_udf));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {a_wr, a_rd, a_clr, b_wr, b_rd, b_clr, c_wr, c_rd, c_clr} = '0;
        a_din = '0; b_din = '0; c_din = '0;
        #12;
        check("a_rst_empty", a_empty, 1);
        check("a_rst_full", a_full, 0);
        check("a_rst_count", a_count, 0);
        check("a_rst_ae", a_ae, 1);
        check("a_rst_af", a_af, 0);
        check("a_rst_dout", a_dout, 0);
        check("a_rst_ovf", a_ovf, 0);
        check("a_rst_udf", a_udf, 0);
        check("c_rst_dout", c_dout, 0);
        step();
        rst_n = 1'b1;

        // Fill eight words; watch thresholds rise.
        a_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_din = 8'(8'h11 + i);
            step();
            check("a_fill_count", a_count, i + 1);
            check("a_fill_ae", a_ae, (i + 1) <= 2);
            check("a_fill_af", a_af, (i + 1) >= 6);
            check("a_fill_full", a_full, i == 7);
        end
        a_wr = 1'b0;

        // Drain eight words; data appears one cycle after each rd_en edge.
        a_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("a_drain_dout", a_dout, 8'h11 + i);
            check("a_drain_count", a_count, 7 - i);
            check("a_drain_af", a_af, (7 - i) >= 6);
            check("a_drain_ae", a_ae, (7 - i) <= 2);
            check("a_drain_empty", a_empty, i == 7);
        end
        a_rd = 1'b0;
        step();
        check("a_hold_dout", a_dout, 8'h18);

        // Overflow: full with simultaneous write/read drops the write.
        a_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_din = 8'(8'h20 + i);
            step();
        end
        check("a_full_again", a_full, 1);
        a_rd = 1'b1; a_din = 8'hEE;
        step();
        check("a_ovf_count", a_count, 7);
        check("a_ovf_flag", a_ovf, 1);
        check("a_ovf_dout", a_dout, 8'h20);
        a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("a_ovf_clr", a_ovf, 0);
        check("a_clr_count", a_count, 7);
        a_rd = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check("a_ovf_drain", a_dout, 8'h21 + i);
        end
        check("a_ovf_empty", a_empty, 1);

        // Underflow: empty with simultaneous write/read stores the write only.
        a_wr = 1'b1; a_din = 8'hEE;
        step();
        a_wr = 1'b0;
        check("a_udf_count", a_count, 1);
        check("a_udf_flag", a_udf, 1);
        check("a_udf_dout", a_dout, 8'h27);
        step();
        a_rd = 1'b0;
        check("a_udf_read", a_dout, 8'hEE);
        check("a_udf_empty", a_empty, 1);
        a_clr = 1'b1;
        step();
        check("a_udf_clr", a_udf, 0);
        a_rd = 1'b1;
        step();
        a_rd = 1'b0; a_clr = 1'b0;
        check("a_set_wins", a_udf, 1);

        // DEPTH=5: pointers wrap several times, order preserved.
        b_wr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            b_din = 8'(i);
            b_rd = (i >= 2);
            step();
            if (i >= 2) check("b_dout", b_dout, i - 2);
            check("b_count", b_count, (i < 2) ? i + 1 : 2);
        end
        b_wr = 1'b0; b_rd = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("b_tail_dout", b_dout, 10 + i);
            check("b_tail_count", b_count, 1 - i);
        end
        b_rd = 1'b0;
        check("b_underflow_clean", b_udf, 0);

        // Fall-through: head visible without rd_en.
        c_wr = 1'b1; c_din = 8'hA5;
        step();
        c_wr = 1'b0;
        check("c_empty_fall", c_empty, 0);
        check("c_dout_a5", c_dout, 8'hA5);
        c_rd = 1'b1;
        step();
        c_rd = 1'b0;
        check("c_pop_empty", c_empty, 1);
        check("c_pop_dout", c_dout, 0);
        c_wr = 1'b1; c_din = 8'hB6;
        step();
        c_din = 8'hC7;
        step();
        c_wr = 1'b0;
        check("c_head_b6", c_dout, 8'hB6);
        c_rd = 1'b1;
        step();
        check("c_head_c7", c_dout, 8'hC7);
        step();
        check("c_drained_dout", c_dout, 0);
        step();
        c_rd = 1'b0;
        check("c_underflow", c_udf, 1);

        // Asynchronous reset mid-cycle while four words stored and writing.
        a_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_din = 8'(8'h31 + i);
            step();
        end
        check("a_pre_rst_count", a_count, 4);
        a_din = 8'h35;
        #3;
        rst_n = 1'b0;
        #1;
        check("a_arst_count", a_count, 0);
        check("a_arst_empty", a_empty, 1);
        check("a_arst_ae", a_ae, 1);
        check("a_arst_dout", a_dout, 0);
        check("a_arst_udf", a_udf, 0);
        a_wr = 1'b0;
        step();
        rst_n = 1'b1;
        a_wr = 1'b1; a_din = 8'h41;
        step();
        a_din = 8'h42;
        step();
        a_wr = 1'b0; a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        check("a_post_rst_first", a_dout, 8'h41);
        check("a_post_rst_count", a_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
